// File: rtl/ahb5_slave_mem.sv
// AHB5 slave backed by a word-organised memory.
// Supports byte, halfword and word transfers, programmable wait states on
// OKAY transfers, and the two-cycle ERROR response for bad transfers.
module ahb5_slave_mem #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [DATA_WIDTH-1:0] HRDATA
);

   localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

   state_t          state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic            pend_q, pend_d;     // zero-wait OKAY data phase in progress
   logic            write_q, write_d;
   logic [1:0]      size_q, size_d;
   logic [IW+1:0]   addr_q, addr_d;

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   logic            ready;
   logic            final_okay;
   logic            accept;
   logic            addr_err;
   logic [IW-1:0]   widx;
   logic [3:0]      strb;
   logic [DATA_WIDTH-1:0] wr_word_d;
   logic            mem_we;
   logic            unused_bits;

   // HTRANS[0] only separates NONSEQ from SEQ, which this slave treats alike
   assign unused_bits = HTRANS[0];
   assign widx        = addr_q[IW+1:2];

   // Data-phase status and address-phase qualification
   always_comb begin
      ready      = (state_q == IDLE) || (state_q == ERR2) ||
                   ((state_q == WAIT) && (cnt_q == 3'd0));
      final_okay = ((state_q == IDLE) && pend_q) ||
                   ((state_q == WAIT) && (cnt_q == 3'd0));
      accept     = HSEL && HREADY && HTRANS[1] && ready;
      addr_err   = ({2'b00, HADDR[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(MEM_DEPTH)) ||
                   (HSIZE > 3'b010) ||
                   ((HSIZE == 3'b001) && HADDR[0]) ||
                   ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
   end

   // Bus outputs: read data only appears in the completing cycle of an OKAY read
   always_comb begin
      HREADYOUT = ready;
      HRESP     = (state_q == ERR1) || (state_q == ERR2);
      HRDATA    = (final_okay && !write_q) ? mem_q[widx] : '0;
   end

   // Byte-lane merge of write data into the addressed word (little-endian lanes)
   always_comb begin
      case (size_q)
         2'b00:   strb = 4'b0001 << addr_q[1:0];
         2'b01:   strb = addr_q[1] ? 4'b1100 : 4'b0011;
         default: strb = 4'b1111;
      endcase
      wr_word_d = mem_q[widx];
      for (int i = 0; i < 4; i++)
         if (strb[i]) wr_word_d[8*i +: 8] = HWDATA[8*i +: 8];
      mem_we = final_okay && write_q;
   end

   // Next-state: new transfers are only taken in a cycle where HREADYOUT is high
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      write_d = write_q;
      size_d  = size_q;
      addr_d  = addr_q;
      if (ready) begin
         state_d = IDLE;
         cnt_d   = 3'd0;
         pend_d  = 1'b0;
         if (accept) begin
            addr_d  = HADDR[IW+1:0];
            write_d = HWRITE;
            size_d  = HSIZE[1:0];
            if (addr_err) begin
               state_d = ERR1;
            end else if (WAIT_STATES == 0) begin
               pend_d = 1'b1;
            end else begin
               state_d = WAIT;
               cnt_d   = 3'(WAIT_STATES);
            end
         end
      end else begin
         case (state_q)
            WAIT:    cnt_d   = cnt_q - 3'd1;
            ERR1:    state_d = ERR2;
            default: ;
         endcase
      end
   end

   // Control registers; reset drops any in-flight transfer
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         pend_q  <= 1'b0;
         write_q <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         write_q <= write_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
      end
   end

   // Storage is not reset; a write lands at the end of its completing cycle
   always_ff @(posedge HCLK) begin
      if (mem_we && !HRESET) mem_q[widx] <= wr_word_d;
   end

endmodule

// File: tb/tb_ahb5_slave_mem.sv
// Bench for ahb5_slave_mem: one zero-wait and one 3-wait instance, a
// transfer-level memory model, and a negedge monitor draining a scoreboard.
module tb_ahb5_slave_mem;

   typedef struct packed {
      logic        err;
      logic        wr;
      logic [31:0] rdata;
   } exp_t;

   localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        hsel      [2];
   logic [31:0] haddr     [2];
   logic [1:0]  htrans    [2];
   logic        hwrite    [2];
   logic [2:0]  hsize     [2];
   logic [31:0] hwdata    [2];
   logic        hready    [2];
   logic        hreadyout [2];
   logic        hresp     [2];
   logic [31:0] hrdata    [2];
   logic        blk       [2];

   int checks = 0;
   int errors = 0;

   logic [31:0] mdl [2][16];
   exp_t sb0[$];
   exp_t sb1[$];

   always #5 clk = ~clk;

   // Single-slave bus per instance, with an optional "other slave stalls" override
   assign hready[0] = hreadyout[0] & ~blk[0];
   assign hready[1] = hreadyout[1] & ~blk[1];

   ahb5_slave_mem #(.WAIT_STATES(0)) u_ws0 (
      .HCLK(clk), .HRESET(rst), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
      .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]), .HREADY(hready[0]),
      .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));

   ahb5_slave_mem #(.WAIT_STATES(3)) u_ws3 (
      .HCLK(clk), .HRESET(rst), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
      .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]), .HREADY(hready[1]),
      .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));

   function automatic int ws(int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic logic is_err(logic [31:0] a, logic [2:0] sz);
      return (a / 4 >= 256) || (sz > 3'd2) ||
             (sz == 3'd1 && a % 2 != 0) || (sz == 3'd2 && a % 4 != 0);
   endfunction

   task automatic chk(string nm, int d, logic [33:0] act, logic [33:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d got {rdy,resp,rdata}=%h want %h at %0t", nm, d, act, exp, $time);
      end
   endtask

   // Monitor: every cycle, compare {HREADYOUT,HRESP,HRDATA} with what the
   // transfer currently in its data phase should show, then note acceptance.
   logic        in_dp [2];
   int          k     [2];
   exp_t        cur   [2];
   logic [33:0] m_exp;
   logic        m_last;

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            in_dp[d] = 1'b0;
            if (d == 0) sb0.delete(); else sb1.delete();
            chk("reset_out", d, {hreadyout[d], hresp[d], hrdata[d]}, {2'b10, 32'h0});
         end else begin
            m_last = 1'b0;
            if (!in_dp[d]) begin
               m_exp = {2'b10, 32'h0};
            end else if (cur[d].err) begin
               m_exp  = (k[d] == 0) ? {2'b01, 32'h0} : {2'b11, 32'h0};
               m_last = (k[d] != 0);
            end else if (k[d] < ws(d)) begin
               m_exp = 34'h0;
            end else begin
               m_exp  = {2'b10, (cur[d].wr ? 32'h0 : cur[d].rdata)};
               m_last = 1'b1;
            end
            chk(in_dp[d] ? "data_phase" : "idle_phase", d,
                {hreadyout[d], hresp[d], hrdata[d]}, m_exp);
            k[d]++;
            if (m_last) in_dp[d] = 1'b0;
            if (hsel[d] && hready[d] && htrans[d][1]) begin
               if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_empty dut%0d accepted transfer with no expectation", d);
               end else begin
                  cur[d]   = (d == 0) ? sb0.pop_front() : sb1.pop_front();
                  in_dp[d] = 1'b1;
                  k[d]     = 0;
               end
            end
         end
      end
   end

   // Wait for the cycle in which the current address phase is taken, then step past it
   task automatic wait_accept(int d);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!hready[d] && n < 50);
      if (!hready[d]) begin
         checks++;
         errors++;
         $display("FAIL timeout dut%0d HREADYOUT stuck low got 0 want 1", d);
      end
      @(posedge clk);
      #1;
   endtask

   // Issue one transfer: compute its expected response from the model, then drive it
   task automatic issue(int d, logic [31:0] a, logic w, logic [2:0] sz,
                        logic [31:0] wd, logic [1:0] tr, bit commit);
      exp_t e;
      int   widx, nb, off;
      e.err   = is_err(a, sz);
      e.wr    = w;
      e.rdata = 32'h0;
      if (!e.err) begin
         widx = a / 4;
         if (!w) begin
            e.rdata = mdl[d][widx];
         end else if (commit) begin
            nb  = 1 << sz;
            off = a % 4;
            for (int i = 0; i < nb; i++)
               mdl[d][widx][8*(off+i) +: 8] = wd[8*(off+i) +: 8];
         end
      end
      if (d == 0) sb0.push_back(e); else sb1.push_back(e);
      hsel[d]   = 1'b1;
      haddr[d]  = a;
      htrans[d] = tr;
      hwrite[d] = w;
      hsize[d]  = sz;
      wait_accept(d);
      hwdata[d] = wd;
   endtask

   task automatic idle_cyc(int d, logic hs, logic [1:0] tr, int n);
      hsel[d]   = hs;
      htrans[d] = tr;
      haddr[d]  = $urandom;
      hwrite[d] = 1'b1;
      for (int i = 0; i < n; i++) wait_accept(d);
   endtask

   task automatic run_dut(int d);
      logic [31:0] a;
      logic [2:0]  sz;
      int          r;
      for (int w = 0; w < 16; w++)
         issue(d, 32'(w * 4), 1'b1, 3'd2, $urandom, (w == 0) ? T_NSEQ : T_SEQ, 1'b1);
      idle_cyc(d, 1'b1, T_IDLE, 1);
      // word write / read-back, then byte merge into the same word
      issue(d, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, T_NSEQ, 1'b1);
      issue(d, 32'h10, 1'b0, 3'd2, 32'h0, T_NSEQ, 1'b1);
      issue(d, 32'h13, 1'b1, 3'd0, 32'h5500_0000, T_NSEQ, 1'b1);
      issue(d, 32'h10, 1'b0, 3'd2, 32'h0, T_NSEQ, 1'b1);
      // unaligned and out-of-range errors, then confirm nothing moved
      issue(d, 32'h02, 1'b0, 3'd2, 32'h0, T_NSEQ, 1'b1);
      issue(d, 32'h400, 1'b0, 3'd2, 32'h0, T_NSEQ, 1'b1);
      issue(d, 32'h00, 1'b0, 3'd2, 32'h0, T_NSEQ, 1'b1);
      issue(d, 32'h10, 1'b0, 3'd2, 32'h0, T_NSEQ, 1'b1);
      // burst writes, then IDLE and deselected BUSY with live-looking data
      issue(d, 32'h0, 1'b1, 3'd2, $urandom, T_NSEQ, 1'b1);
      issue(d, 32'h4, 1'b1, 3'd2, $urandom, T_SEQ, 1'b1);
      issue(d, 32'h8, 1'b1, 3'd2, $urandom, T_SEQ, 1'b1);
      idle_cyc(d, 1'b1, T_IDLE, 1);
      hwdata[d] = 32'hFFFF_FFFF;
      idle_cyc(d, 1'b0, T_BUSY, 2);
      issue(d, 32'h0, 1'b0, 3'd2, 32'h0, T_NSEQ, 1'b1);
      issue(d, 32'h4, 1'b0, 3'd2, 32'h0, T_SEQ, 1'b1);
      issue(d, 32'h8, 1'b0, 3'd2, 32'h0, T_SEQ, 1'b1);
      // randomized mix
      for (int n = 0; n < 80; n++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            idle_cyc(d, 1'b1, T_IDLE, $urandom_range(1, 2));
         end else if (r == 1) begin
            idle_cyc(d, 1'b0, 2'($urandom_range(0, 3)), 1);
         end else begin
            a  = ($urandom_range(0, 9) == 0) ? 32'h400 + 32'($urandom_range(0, 255))
                                             : 32'($urandom_range(0, 63));
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7))
                                             : 3'($urandom_range(0, 2));
            issue(d, a, 1'($urandom_range(0, 1)), sz, $urandom,
                  2'($urandom_range(2, 3)), 1'b1);
         end
      end
      idle_cyc(d, 1'b0, T_IDLE, 2);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         hsel[d] = 1'b0; haddr[d] = 32'h0; htrans[d] = T_IDLE; hwrite[d] = 1'b0;
         hsize[d] = 3'd2; hwdata[d] = 32'h0; blk[d] = 1'b0;
      end
      #1 rst = 1'b1;
      #1;
      chk("reset_async", 0, {hreadyout[0], hresp[0], hrdata[0]}, {2'b10, 32'h0});
      chk("reset_async", 1, {hreadyout[1], hresp[1], hrdata[1]}, {2'b10, 32'h0});
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      run_dut(0);
      run_dut(1);

      // Reset in the second cycle of a 3-wait write: the write must be dropped
      issue(1, 32'h20, 1'b1, 3'd2, 32'hCAFEF00D, T_NSEQ, 1'b0);
      hsel[1]   = 1'b0;
      htrans[1] = T_IDLE;
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("reset_midxfer", 1, {hreadyout[1], hresp[1], hrdata[1]}, {2'b10, 32'h0});
      @(posedge clk);
      #1 rst = 1'b0;
      issue(1, 32'h20, 1'b0, 3'd2, 32'h0, T_NSEQ, 1'b1);
      idle_cyc(1, 1'b0, T_IDLE, 2);

      // Address phase presented while another slave holds HREADY low, then withdrawn
      blk[0]    = 1'b1;
      hsel[0]   = 1'b1;
      haddr[0]  = 32'h4;
      htrans[0] = T_NSEQ;
      hwrite[0] = 1'b1;
      hsize[0]  = 3'd2;
      hwdata[0] = 32'h1234_5678;
      repeat (2) begin @(posedge clk); #1; end
      hsel[0]   = 1'b0;
      htrans[0] = T_IDLE;
      @(posedge clk);
      #1 blk[0] = 1'b0;
      issue(0, 32'h4, 1'b0, 3'd2, 32'h0, T_NSEQ, 1'b1);
      idle_cyc(0, 1'b0, T_IDLE, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
